arb_rr4: RTL and testbench



---
 rtl/arb_rr4_pkg.sv | 34 +++
 rtl/arb_rr4_if.sv | 34 +++
 rtl/arb_rr4_dec2to4.sv | 16 +
 rtl/arb_rr4.sv | 109 ++++++++++
 tb/tb_arb_rr4.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/arb_rr4_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the four-requester round-robin arbiter.
//   NREQ     : number of requesters (4)
//   IDX_W    : width of a requester index (2)
//   state_t  : arbiter FSM state encoding (ST_IDLE / ST_GRANT)
//   rr_pick  : wrap-around priority scan, returns the first set request bit
//              at or after the start position (mod NREQ)
// ---------------------------------------------------------------------------
package arb_pkg;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // The loop walks the offsets from farthest to nearest so the nearest set
  // bit to the start position is the last one written and therefore wins.
  // With no bit set the result is the start position; callers only use the
  // result when at least one request is pending.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] req,
                                               input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] idx;
    rr_pick = start;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = start + IDX_W'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/arb_rr4_if.sv
// ---------------------------------------------------------------------------
// arb_rr4_if
// Request/grant bundle between the requesters and the arbiter.
//   req       : request vector, bit i belongs to requester i
//   gnt       : one-hot grant (all-zero when idle)
//   gnt_idx   : registered winner index, meaningful only with gnt_valid
//   gnt_valid : high while a grant is active
// Modports:
//   master : requester side (drives req, observes the grant)
//   slave  : arbiter side (observes req, drives the grant)
// ---------------------------------------------------------------------------
interface arb_rr4_if;
  import arb_pkg::*;

  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;

  modport master (
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_valid
  );

endinterface

// File: rtl/arb_rr4_dec2to4.sv
// ---------------------------------------------------------------------------
// dec2to4
// Purely combinational 2-to-4 decoder with enable.
//   sel : 2-bit select
//   en  : enable; when low the output is all-zero
//   y   : one-hot decode of sel, or zero
// ---------------------------------------------------------------------------
module dec2to4 (
  input  logic [1:0] sel,
  input  logic       en,
  output logic [3:0] y
);

  assign y = en ? (4'b0001 << sel) : 4'b0000;

endmodule

// File: rtl/arb_rr4.sv
// ---------------------------------------------------------------------------
// arb_rr4
// Four-requester round-robin arbiter. A registered 2-bit winner index is
// decoded into a one-hot grant. A requester may keep the grant while it
// keeps requesting, but after HOLD_MAX consecutive cycles it is forced to
// hand over if anyone else is waiting.
// Parameters:
//   HOLD_MAX : maximum consecutive grant cycles under contention (1..255)
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : request/grant bundle (slave side)
// ---------------------------------------------------------------------------
module arb_rr4
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  arb_rr4_if.slave   bus
);

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [IDX_W-1:0] ptr_q,   ptr_d;
  logic [7:0]       hcnt_q,  hcnt_d;

  logic [NREQ-1:0]  cur_mask;
  logic             cur_req;
  logic             others;
  logic             handover;
  logic [IDX_W-1:0] next_ptr;

  // Current grantee's request and whether anyone else is waiting.
  assign cur_mask = NREQ'(1) << idx_q;
  assign cur_req  = |(bus.req & cur_mask);
  assign others   = |(bus.req & ~cur_mask);
  assign next_ptr = idx_q + IDX_W'(1);

  // A timeout is treated exactly like a release: the pointer moves past the
  // grantee so it re-enters the scan last.
  assign handover = !cur_req || ((hcnt_q == HOLD_LIM) && others);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      hcnt_q  <= hcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    hcnt_d  = hcnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          state_d = ST_GRANT;
          idx_d   = rr_pick(bus.req, ptr_q);
          hcnt_d  = 8'd1;
        end
      end

      ST_GRANT: begin
        if (handover) begin
          ptr_d = next_ptr;
          // On release the grantee's bit is already clear; on timeout
          // others is set, so the scan from next_ptr finds someone else
          // before it can wrap back to the old grantee.
          if (|bus.req) begin
            state_d = ST_GRANT;
            idx_d   = rr_pick(bus.req, next_ptr);
            hcnt_d  = 8'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (hcnt_q != HOLD_LIM) begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = (state_q == ST_GRANT);

  dec2to4 u_dec (
    .sel (idx_q),
    .en  (state_q == ST_GRANT),
    .y   (bus.gnt)
  );

endmodule

// File: tb/tb_arb_rr4.sv
// ---------------------------------------------------------------------------
// tb_arb_rr4
// Directed bench for arb_rr4. Two arbiters share clock and reset: one with
// HOLD_MAX=8 for the general sequence, one with HOLD_MAX=2 for the fairness
// rotation. Inputs change 1 ns after each rising edge and outputs are
// checked at the same point, so each check reflects the edge just taken.
// ---------------------------------------------------------------------------
module tb_arb_rr4;
  import arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  int vectors     = 0;
  int miscompares = 0;

  arb_rr4_if bus8 ();
  arb_rr4_if bus2 ();

  arb_rr4 #(.HOLD_MAX(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  arb_rr4 #(.HOLD_MAX(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  always #5 clk = ~clk;

  // Drive both request vectors and reset, then advance one rising edge.
  task automatic applyStimulus(input logic [3:0] r8, input logic [3:0] r2,
                               input logic rn);
    bus8.req = r8;
    bus2.req = r2;
    rst_n    = rn;
    @(posedge clk);
    #1;
  endtask

  // Compare grant, valid and (when a grant is expected) the index.
  task automatic checkOutput(input string tag, input logic use2,
                             input logic [3:0] exp_gnt);
    logic [3:0] g;
    logic       v;
    logic [1:0] i;
    logic       ev;
    logic [1:0] ei;
    g  = use2 ? bus2.gnt       : bus8.gnt;
    v  = use2 ? bus2.gnt_valid : bus8.gnt_valid;
    i  = use2 ? bus2.gnt_idx   : bus8.gnt_idx;
    ev = |exp_gnt;
    ei = exp_gnt[3] ? 2'd3 : exp_gnt[2] ? 2'd2 : exp_gnt[1] ? 2'd1 : 2'd0;
    if (!ev) i = 2'd0;
    vectors++;
    assert ({g, v, i} === {exp_gnt, ev, ei})
    else begin
      miscompares++;
      $error("[TB] FAIL %s: gnt=%b valid=%b idx=%0d, expected gnt=%b valid=%b idx=%0d",
             tag, g, v, i, exp_gnt, ev, ei);
    end
  endtask

  logic [3:0] fair_seq [9];

  initial begin
    fair_seq = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                 4'b0100, 4'b1000, 4'b1000, 4'b0001};

    // Reset held 3 cycles with every requester asking.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'b1111, 4'b0000, 1'b0);
      checkOutput("reset_hold", 1'b0, 4'b0000);
    end
    vectors++;
    assert (bus8.gnt_idx === 2'b00 && dut2.bus.gnt_idx === 2'b00)
    else begin
      miscompares++;
      $error("[TB] FAIL reset_idx: idx8=%0d idx2=%0d, expected 0 and 0",
             bus8.gnt_idx, bus2.gnt_idx);
    end
    checkOutput("reset_idle2", 1'b1, 4'b0000);

    // First edge after reset release: requester 0 wins.
    applyStimulus(4'b1111, 4'b0000, 1'b1);
    checkOutput("post_reset", 1'b0, 4'b0001);

    // Single requester 2 for five cycles, then drop.
    for (int c = 0; c < 5; c++) begin
      applyStimulus(4'b0100, 4'b0000, 1'b1);
      checkOutput("single_req2", 1'b0, 4'b0100);
    end
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("single_drop", 1'b0, 4'b0000);

    // Pointer now 3: all requesting, requester 3 wins and holds 8 cycles.
    applyStimulus(4'b1111, 4'b0000, 1'b1);
    checkOutput("ptr3_first", 1'b0, 4'b1000);
    for (int c = 0; c < 7; c++) begin
      applyStimulus(4'b1111, 4'b0000, 1'b1);
      checkOutput("hold8", 1'b0, 4'b1000);
    end
    applyStimulus(4'b1111, 4'b0000, 1'b1);
    checkOutput("timeout_wrap", 1'b0, 4'b0001);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("idle_a", 1'b0, 4'b0000);

    // Release handoff without a bubble.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'b0001, 4'b0000, 1'b1);
      checkOutput("handoff_req0", 1'b0, 4'b0001);
    end
    applyStimulus(4'b1010, 4'b0000, 1'b1);
    checkOutput("handoff_to1", 1'b0, 4'b0010);
    applyStimulus(4'b1000, 4'b0000, 1'b1);
    checkOutput("handoff_to3", 1'b0, 4'b1000);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("idle_b", 1'b0, 4'b0000);

    // Lone requester 1 keeps the grant past HOLD_MAX; requester 3 then
    // arrives with the counter saturated and takes over at the next edge.
    for (int c = 0; c < 11; c++) begin
      applyStimulus(4'b0010, 4'b0000, 1'b1);
      checkOutput("lone_req1", 1'b0, 4'b0010);
    end
    applyStimulus(4'b1010, 4'b0000, 1'b1);
    checkOutput("lone_timeout", 1'b0, 4'b1000);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("idle_c", 1'b0, 4'b0000);

    // Leave the pointer at 3, regrant requester 2, then reset mid-grant.
    applyStimulus(4'b0100, 4'b0000, 1'b1);
    checkOutput("pre_rst_g2", 1'b0, 4'b0100);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("pre_rst_idle", 1'b0, 4'b0000);
    applyStimulus(4'b0100, 4'b0000, 1'b1);
    checkOutput("pre_rst_regrant", 1'b0, 4'b0100);
    applyStimulus(4'b1100, 4'b0000, 1'b0);
    checkOutput("mid_reset", 1'b0, 4'b0000);
    applyStimulus(4'b1100, 4'b0000, 1'b1);
    checkOutput("post_mid_reset", 1'b0, 4'b0100);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("idle_d", 1'b0, 4'b0000);

    // Fairness rotation on the HOLD_MAX=2 arbiter.
    for (int c = 0; c < 9; c++) begin
      applyStimulus(4'b0000, 4'b1111, 1'b1);
      checkOutput("fair_rr", 1'b1, fair_seq[c]);
    end
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("fair_idle", 1'b1, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
